// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and default widths for the clock-gate controller.
package clkgate_ctrl_pkg;

  localparam int DEF_IDLE_W = 8;
  localparam int DEF_WAKE_W = 4;
  localparam int DEF_GCNT_W = 16;

  typedef enum logic [1:0] {
    CG_RUN  = 2'd0,
    CG_REQ  = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_e;

endpackage

// File: rtl/cg_satcnt.sv
// Saturating up-counter: clear wins over increment, holds at all ones.
module cg_satcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc until all ones; i_clr returns to zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/clkgate_ctrl.sv
// Idle-detecting controller for a single ICG (drives EN and SE).
//
// state | meaning
// RUN   | clock running, counting idle cycles toward a stop request
// REQ   | stop_req raised, waiting for stop_ack (any activity aborts)
// OFF   | enable dropped, clock gated, waiting for go_on
// WAKE  | enable restored, counting settle cycles before clk_ready
module clkgate_ctrl
  import clkgate_ctrl_pkg::*;
#(
  parameter int IDLE_W = DEF_IDLE_W,
  parameter int WAKE_W = DEF_WAKE_W,
  parameter int GCNT_W = DEF_GCNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_en,
  input  logic [IDLE_W-1:0] idle_thr,
  input  logic [WAKE_W-1:0] wake_dly,
  input  logic              scan_mode,
  input  logic              busy,
  input  logic              wake,
  output logic              stop_req,
  input  logic              stop_ack,
  output logic              cg_en,
  output logic              cg_se,
  output logic              clk_ready,
  output logic [GCNT_W-1:0] gate_cnt
);

  cg_state_e         r_state;
  cg_state_e         w_state_nxt;
  logic              w_go_on;
  logic              w_idle;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic [WAKE_W-1:0] w_wake_cnt;
  logic              w_idle_clr;
  logic              w_idle_inc;
  logic              w_wake_clr;
  logic              w_wake_inc;
  logic              w_gate_inc;
  logic              r_cg_en;
  logic              r_stop_req;
  logic              r_clk_ready;

  assign w_go_on = !cfg_en || scan_mode || wake;
  assign w_idle  = !busy && !w_go_on;

  // Next-state decode and counter controls. The idle counter only runs in
  // RUN so every return to RUN restarts the full idle threshold.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_clr  = !w_idle || (r_state != CG_RUN);
    w_idle_inc  = 1'b0;
    w_wake_clr  = 1'b0;
    w_wake_inc  = 1'b0;
    w_gate_inc  = 1'b0;
    case (r_state)
      CG_RUN: begin
        if (w_idle) begin
          if (w_idle_cnt == idle_thr) w_state_nxt = CG_REQ;
          else                        w_idle_inc  = 1'b1;
        end
      end
      CG_REQ: begin
        if (!w_idle) begin
          w_state_nxt = CG_RUN;
        end else if (stop_ack) begin
          w_state_nxt = CG_OFF;
          w_gate_inc  = 1'b1;
        end
      end
      CG_OFF: begin
        if (w_go_on) begin
          w_state_nxt = CG_WAKE;
          w_wake_clr  = 1'b1;
        end
      end
      CG_WAKE: begin
        if (w_wake_cnt == wake_dly) w_state_nxt = CG_RUN;
        else                        w_wake_inc  = 1'b1;
      end
      default: w_state_nxt = CG_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= CG_RUN;
    else         r_state <= w_state_nxt;
  end

  // Outputs registered from the next state so they change only on clk posedge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cg_en     <= 1'b1;
      r_stop_req  <= 1'b0;
      r_clk_ready <= 1'b1;
    end else begin
      r_cg_en     <= (w_state_nxt != CG_OFF);
      r_stop_req  <= (w_state_nxt == CG_REQ) || (w_state_nxt == CG_OFF);
      r_clk_ready <= (w_state_nxt == CG_RUN) || (w_state_nxt == CG_REQ);
    end
  end

  cg_satcnt #(.W(IDLE_W)) u_idle_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_idle_clr),
    .i_inc  (w_idle_inc),
    .o_cnt  (w_idle_cnt)
  );

  cg_satcnt #(.W(WAKE_W)) u_wake_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (w_wake_clr),
    .i_inc  (w_wake_inc),
    .o_cnt  (w_wake_cnt)
  );

  cg_satcnt #(.W(GCNT_W)) u_gate_cnt (
    .clk    (clk),
    .resetn (resetn),
    .i_clr  (1'b0),
    .i_inc  (w_gate_inc),
    .o_cnt  (gate_cnt)
  );

  assign cg_en     = r_cg_en;
  assign stop_req  = r_stop_req;
  assign clk_ready = r_clk_ready;
  assign cg_se     = scan_mode;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl: a per-cycle vector table for the basic
// gate/wake flow, then hand sequences for the multi-cycle corners.
module tb_clkgate_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_en;
  logic [7:0]  idle_thr;
  logic [3:0]  wake_dly;
  logic        scan_mode;
  logic        busy;
  logic        wake;
  logic        stop_ack;
  logic        stop_req, cg_en, cg_se, clk_ready;
  logic [15:0] gate_cnt;
  logic        s_stop_req, s_cg_en, s_cg_se, s_clk_ready;
  logic [1:0]  s_gate_cnt;

  int n_checks = 0;
  int n_errors = 0;

  clkgate_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_en    (cfg_en),
    .idle_thr  (idle_thr),
    .wake_dly  (wake_dly),
    .scan_mode (scan_mode),
    .busy      (busy),
    .wake      (wake),
    .stop_req  (stop_req),
    .stop_ack  (stop_ack),
    .cg_en     (cg_en),
    .cg_se     (cg_se),
    .clk_ready (clk_ready),
    .gate_cnt  (gate_cnt)
  );

  clkgate_ctrl #(.GCNT_W(2)) dut_sat (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_en    (cfg_en),
    .idle_thr  (idle_thr),
    .wake_dly  (wake_dly),
    .scan_mode (scan_mode),
    .busy      (busy),
    .wake      (wake),
    .stop_req  (s_stop_req),
    .stop_ack  (stop_ack),
    .cg_en     (s_cg_en),
    .cg_se     (s_cg_se),
    .clk_ready (s_clk_ready),
    .gate_cnt  (s_gate_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        wake;
    logic        ack;
    logic        e_req;
    logic        e_en;
    logic        e_rdy;
    logic [15:0] e_g;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic b, input logic w, input logic a,
                              input logic r, input logic e, input logic rd,
                              input logic [15:0] g);
    vec_t v;
    v.busy = b; v.wake = w; v.ack = a;
    v.e_req = r; v.e_en = e; v.e_rdy = rd; v.e_g = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic r, input logic e,
                          input logic rd, input logic [15:0] g);
    chk({tag, ".stop_req"},  {15'd0, stop_req},  {15'd0, r});
    chk({tag, ".cg_en"},     {15'd0, cg_en},     {15'd0, e});
    chk({tag, ".clk_ready"}, {15'd0, clk_ready}, {15'd0, rd});
    chk({tag, ".gate_cnt"},  gate_cnt,           g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Gate/wake flow with idle_thr=3, wake_dly=2. Expected values are after the edge.
    vecs[0]  = mk(1, 0, 0,  0, 1, 1, 16'd0);
    vecs[1]  = mk(0, 0, 0,  0, 1, 1, 16'd0);
    vecs[2]  = mk(0, 0, 0,  0, 1, 1, 16'd0);
    vecs[3]  = mk(0, 0, 0,  0, 1, 1, 16'd0);
    vecs[4]  = mk(0, 0, 0,  1, 1, 1, 16'd0);
    vecs[5]  = mk(0, 0, 0,  1, 1, 1, 16'd0);
    vecs[6]  = mk(0, 0, 1,  1, 0, 0, 16'd1);
    vecs[7]  = mk(1, 0, 0,  1, 0, 0, 16'd1);
    vecs[8]  = mk(1, 0, 1,  1, 0, 0, 16'd1);
    vecs[9]  = mk(1, 1, 0,  0, 1, 0, 16'd1);
    vecs[10] = mk(1, 0, 0,  0, 1, 0, 16'd1);
    vecs[11] = mk(1, 0, 0,  0, 1, 0, 16'd1);
    vecs[12] = mk(1, 0, 0,  0, 1, 1, 16'd1);
    vecs[13] = mk(0, 0, 1,  0, 1, 1, 16'd1);
    vecs[14] = mk(0, 0, 1,  0, 1, 1, 16'd1);
    vecs[15] = mk(1, 0, 0,  0, 1, 1, 16'd1);

    resetn = 1'b0; cfg_en = 1'b1; idle_thr = 8'd3; wake_dly = 4'd2;
    scan_mode = 1'b0; busy = 1'b1; wake = 1'b0; stop_ack = 1'b0;
    step(); step();
    chk_outs("reset", 0, 1, 1, 16'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      busy = vecs[i].busy; wake = vecs[i].wake; stop_ack = vecs[i].ack;
      step();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_en, vecs[i].e_rdy, vecs[i].e_g);
    end

    // Wake with wake_dly=5: clk_ready exactly 6 edges after the wake sample.
    idle_thr = 8'd0; wake_dly = 4'd5; busy = 1'b0;
    step();
    chk("wk.req_up", {15'd0, stop_req}, 16'd1);
    stop_ack = 1'b1;
    step();
    chk_outs("wk.off", 1, 0, 0, 16'd2);
    stop_ack = 1'b0; busy = 1'b1; wake = 1'b1;
    step();
    chk_outs("wk.edge0", 0, 1, 0, 16'd2);
    wake = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("wk.edge%0d.rdy", i), {15'd0, clk_ready}, 16'd0);
      chk($sformatf("wk.edge%0d.req", i), {15'd0, stop_req}, 16'd0);
    end
    step();
    chk_outs("wk.edge6", 0, 1, 1, 16'd2);

    // Abort: busy and stop_ack together in REQ return to RUN without gating.
    busy = 1'b0;
    step();
    chk("ab.req_up", {15'd0, stop_req}, 16'd1);
    busy = 1'b1; stop_ack = 1'b1;
    step();
    chk_outs("ab.run", 0, 1, 1, 16'd2);
    stop_ack = 1'b0;
    step();
    chk_outs("ab.stay", 0, 1, 1, 16'd2);

    // cfg_en=0 in OFF wakes and keeps the clock on.
    busy = 1'b0;
    step();
    stop_ack = 1'b1;
    step();
    chk_outs("cfg.off", 1, 0, 0, 16'd3);
    stop_ack = 1'b0; cfg_en = 1'b0; wake_dly = 4'd0;
    step();
    chk_outs("cfg.wake", 0, 1, 0, 16'd3);
    step();
    chk_outs("cfg.run", 0, 1, 1, 16'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_outs($sformatf("cfg.hold%0d", i), 0, 1, 1, 16'd3);
    end
    cfg_en = 1'b1; busy = 1'b1;
    step();

    // Scan mode: SE follows combinationally and no stop request is issued.
    scan_mode = 1'b1;
    #1;
    chk("scan.se_on", {15'd0, cg_se}, 16'd1);
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_outs($sformatf("scan.hold%0d", i), 0, 1, 1, 16'd3);
    end
    scan_mode = 1'b0;
    #1;
    chk("scan.se_off", {15'd0, cg_se}, 16'd0);
    busy = 1'b1;
    step();

    // Asynchronous reset while gated.
    busy = 1'b0;
    step();
    stop_ack = 1'b1;
    step();
    chk_outs("rst.off", 1, 0, 0, 16'd4);
    stop_ack = 1'b0; busy = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk_outs("rst.async", 0, 1, 1, 16'd0);
    chk("rst.sat_gcnt", {14'd0, s_gate_cnt}, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk_outs("rst.run", 0, 1, 1, 16'd0);

    // Saturation: five gate/wake rounds.
    idle_thr = 8'd0; wake_dly = 4'd0;
    for (int i = 0; i < 5; i++) begin
      busy = 1'b0;
      step();
      stop_ack = 1'b1;
      step();
      stop_ack = 1'b0; busy = 1'b1; wake = 1'b1;
      step();
      wake = 1'b0;
      step();
      chk_outs($sformatf("sat%0d", i), 0, 1, 1, 16'(i + 1));
      chk($sformatf("sat%0d.gcnt2", i), {14'd0, s_gate_cnt}, (i + 1 > 3) ? 16'd3 : 16'(i + 1));
    end
    chk("sat.final", {14'd0, s_gate_cnt}, 16'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
